helppll_loopfilter: RTL and testbench

- Consumer of the helper-PLL frequency detector. Takes each signed `freqdiff` sample with its one-cycle strobe and runs a PI loop filter with fractional accumulation.
- Drives an unsigned tune word to the helper-oscillator DAC writer over a valid/ready handshake.
- Has an acquisition/track state machine with lock detection, hold and strobe-timeout. Runs entirely in the reference-clock domain that produces `freqdiff`.

---
 rtl/helppll_loopfilter.sv | 244 ++++++++++++++++++++++++
 tb/tb_helppll_loopfilter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/helppll_loopfilter.sv
// Helper-PLL PI loop filter: fractional integral accumulator, registered tune word
// on a valid/ready handshake, and an IDLE/ACQ/TRACK/HOLD lock state machine.
module helppll_loopfilter #(
  parameter int DWIDTH     = 32,
  parameter int OUTW       = 16,
  parameter int FRAC       = 16,
  parameter int KP_SHIFT   = 4,
  parameter int KI_ACQ     = 2,
  parameter int KI_TRK     = 8,
  parameter int INIT_TUNE  = 32768,
  parameter int LOCK_TOL   = 2,
  parameter int LOCK_CNT   = 8,
  parameter int UNLOCK_TOL = 16,
  parameter int TIMEOUT    = 65535
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              hold,
  input  logic [DWIDTH-1:0] freqdiff,
  input  logic              stb_freqdiff,
  output logic [OUTW-1:0]   tune,
  output logic              tune_valid,
  input  logic              tune_ready,
  output logic              locked,
  output logic [1:0]        state_o,
  output logic              overrun,
  output logic              stale,
  output logic [7:0]        unlock_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACQ   = 2'd1,
    ST_TRACK = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  localparam int AW  = OUTW + FRAC + 2;
  // Working width holds acc minus the largest shifted sample without overflow.
  localparam int WW  = ((AW > DWIDTH + FRAC) ? AW : DWIDTH + FRAC) + 2;
  localparam int LCW = $clog2(LOCK_CNT + 1);
  localparam int TW  = $clog2(TIMEOUT + 1);

  localparam logic signed [WW-1:0] ACC_MAX  = {{(WW-OUTW){1'b0}}, {OUTW{1'b1}}} << FRAC;
  localparam logic signed [AW-1:0] ACC_INIT = AW'(INIT_TUNE) << FRAC;

  function automatic logic signed [AW-1:0] sat_acc(input logic signed [WW-1:0] v);
    if (v < 0)            return '0;
    else if (v > ACC_MAX) return AW'(ACC_MAX);
    else                  return AW'(v);
  endfunction

  // The most negative sample has no positive twin; it saturates to the largest magnitude.
  function automatic logic [DWIDTH-1:0] magnitude(input logic [DWIDTH-1:0] v);
    if (v == {1'b1, {(DWIDTH-1){1'b0}}}) return {1'b0, {(DWIDTH-1){1'b1}}};
    else if (v[DWIDTH-1])                return -v;
    else                                 return v;
  endfunction

  state_t                  state_q, state_d, saved_q, saved_d;
  logic signed [AW-1:0]    acc_q, acc_d;
  logic [DWIDTH-1:0]       fdr_q, fdr_d;
  logic                    upd_q, upd_d;
  logic [OUTW-1:0]         tune_q, tune_d;
  logic                    tv_q, tv_d;
  logic                    locked_q, locked_d;
  logic                    overrun_q, overrun_d;
  logic                    stale_q, stale_d;
  logic [7:0]              ucnt_q, ucnt_d;
  logic [LCW-1:0]          lcnt_q, lcnt_d;
  logic [TW-1:0]           tcnt_q, tcnt_d;

  logic signed [WW-1:0]    fd_ext, fdr_ext, acc_ext, int_step;
  logic signed [AW-1:0]    acc_upd;
  logic [OUTW-1:0]         tune_calc, issue_tune;
  logic [DWIDTH-1:0]       fd_mag;
  logic                    active, in_lock, lose_lock, lock_hit, to_hit, issue;

  assign fd_ext    = {{(WW-DWIDTH){freqdiff[DWIDTH-1]}}, freqdiff};
  assign fdr_ext   = {{(WW-DWIDTH){fdr_q[DWIDTH-1]}}, fdr_q};
  assign acc_ext   = {{(WW-AW){acc_q[AW-1]}}, acc_q};
  assign int_step  = (state_q == ST_TRACK) ? (fd_ext <<< (FRAC - KI_TRK))
                                           : (fd_ext <<< (FRAC - KI_ACQ));
  assign acc_upd   = sat_acc(acc_ext - int_step);
  assign tune_calc = OUTW'(sat_acc(acc_ext - (fdr_ext <<< (FRAC - KP_SHIFT))) >>> FRAC);

  assign fd_mag    = magnitude(freqdiff);
  assign in_lock   = fd_mag <= DWIDTH'(LOCK_TOL);
  assign lose_lock = fd_mag >  DWIDTH'(UNLOCK_TOL);
  assign lock_hit  = in_lock && (lcnt_q == LCW'(LOCK_CNT - 1));
  assign active    = (state_q == ST_ACQ) || (state_q == ST_TRACK);
  assign to_hit    = active && !stb_freqdiff && (tcnt_q == TW'(TIMEOUT - 1));

  // NOTE: asynchronous active-low reset; all state uses non-blocking assignment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      saved_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
    end
  end

  // NOTE: every combinational output is defaulted first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    saved_d = saved_q;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_ACQ;
        ST_ACQ, ST_TRACK: begin
          if (hold) begin
            state_d = ST_HOLD;
            saved_d = state_q;
          end else if (to_hit) begin
            state_d = ST_ACQ;
          end else if (stb_freqdiff) begin
            if (state_q == ST_ACQ && lock_hit)        state_d = ST_TRACK;
            else if (state_q == ST_TRACK && lose_lock) state_d = ST_ACQ;
          end
        end
        ST_HOLD: if (!hold) state_d = saved_q;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    acc_d      = acc_q;
    fdr_d      = fdr_q;
    upd_d      = 1'b0;
    tune_d     = tune_q;
    tv_d       = tv_q && !tune_ready;
    locked_d   = locked_q;
    overrun_d  = overrun_q;
    stale_d    = stale_q;
    ucnt_d     = ucnt_q;
    lcnt_d     = lcnt_q;
    tcnt_d     = tcnt_q;
    issue      = 1'b0;
    issue_tune = tune_calc;
    if (!enable) begin
      locked_d = 1'b0;
      tv_d     = 1'b0;
      lcnt_d   = '0;
      tcnt_d   = '0;
    end else begin
      issue = upd_q;
      case (state_q)
        ST_IDLE: begin
          acc_d      = ACC_INIT;
          issue      = 1'b1;
          issue_tune = OUTW'(INIT_TUNE);
          lcnt_d     = '0;
          tcnt_d     = '0;
        end
        ST_ACQ, ST_TRACK: begin
          if (!hold) begin
            if (to_hit) begin
              locked_d = 1'b0;
              stale_d  = 1'b1;
              tcnt_d   = '0;
              lcnt_d   = '0;
            end else if (stb_freqdiff) begin
              tcnt_d = '0;
              acc_d  = acc_upd;
              fdr_d  = freqdiff;
              upd_d  = 1'b1;
              if (state_q == ST_ACQ) begin
                if (lock_hit) begin
                  locked_d = 1'b1;
                  lcnt_d   = '0;
                end else if (in_lock) begin
                  lcnt_d = lcnt_q + LCW'(1);
                end else begin
                  lcnt_d = '0;
                end
              end else if (lose_lock) begin
                locked_d = 1'b0;
                if (ucnt_q != 8'hFF) ucnt_d = ucnt_q + 8'd1;
              end
            end else begin
              tcnt_d = tcnt_q + TW'(1);
            end
          end
        end
        ST_HOLD: begin
          if (!hold) begin
            lcnt_d = '0;
            tcnt_d = '0;
          end
        end
        default: ;
      endcase
      // Latest tune wins; replacing one the DAC writer has not taken is flagged.
      if (issue) begin
        tune_d = issue_tune;
        tv_d   = 1'b1;
        if (tv_q && !tune_ready) overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= ACC_INIT;
      fdr_q     <= '0;
      upd_q     <= 1'b0;
      tune_q    <= OUTW'(INIT_TUNE);
      tv_q      <= 1'b0;
      locked_q  <= 1'b0;
      overrun_q <= 1'b0;
      stale_q   <= 1'b0;
      ucnt_q    <= '0;
      lcnt_q    <= '0;
      tcnt_q    <= '0;
    end else begin
      acc_q     <= acc_d;
      fdr_q     <= fdr_d;
      upd_q     <= upd_d;
      tune_q    <= tune_d;
      tv_q      <= tv_d;
      locked_q  <= locked_d;
      overrun_q <= overrun_d;
      stale_q   <= stale_d;
      ucnt_q    <= ucnt_d;
      lcnt_q    <= lcnt_d;
      tcnt_q    <= tcnt_d;
    end
  end

  assign tune       = tune_q;
  assign tune_valid = tv_q;
  assign locked     = locked_q;
  assign state_o    = state_q;
  assign overrun    = overrun_q;
  assign stale      = stale_q;
  assign unlock_cnt = ucnt_q;

endmodule

// File: tb/tb_helppll_loopfilter.sv
// Self-checking bench for helppll_loopfilter: directed scenarios plus random traffic,
// every cycle compared against an integer-arithmetic model of the loop filter.
module tb_helppll_loopfilter;

  localparam int     S_IDLE = 0, S_ACQ = 1, S_TRACK = 2, S_HOLD = 3;
  localparam longint SCALE  = 65536;
  localparam longint ACC_HI = 65535 * 65536;
  localparam int     TIMEOUT = 65535;

  logic        clk, rst_n, enable, hold, stb_freqdiff, tune_ready;
  logic [31:0] freqdiff;
  logic [15:0] tune;
  logic        tune_valid, locked, overrun, stale;
  logic [1:0]  state_o;
  logic [7:0]  unlock_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  int     m_state, m_saved, m_tune, m_ucnt, m_lcnt, m_tcnt;
  longint m_acc, m_fdr;
  bit     m_upd, m_tv, m_locked, m_ovr, m_stale;

  helppll_loopfilter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .hold         (hold),
    .freqdiff     (freqdiff),
    .stb_freqdiff (stb_freqdiff),
    .tune         (tune),
    .tune_valid   (tune_valid),
    .tune_ready   (tune_ready),
    .locked       (locked),
    .state_o      (state_o),
    .overrun      (overrun),
    .stale        (stale),
    .unlock_cnt   (unlock_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0d (0x%0h) expected=%0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic longint clamp_acc(input longint v);
    if (v < 0) return 0;
    if (v > ACC_HI) return ACC_HI;
    return v;
  endfunction

  function automatic longint mag(input longint v);
    if (v == -64'sd2147483648) return 2147483647;
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_reset();
    m_state = S_IDLE; m_saved = S_IDLE;
    m_acc = 32768 * SCALE; m_fdr = 0; m_upd = 0;
    m_tune = 32768; m_tv = 0; m_locked = 0; m_ovr = 0; m_stale = 0;
    m_ucnt = 0; m_lcnt = 0; m_tcnt = 0;
  endtask

  // One rising edge of the loop, computed from the pre-edge state and inputs.
  task automatic model_step();
    int     n_state = m_state, n_saved = m_saved, n_tune = m_tune;
    int     n_ucnt = m_ucnt, n_lcnt = m_lcnt, n_tcnt = m_tcnt;
    longint n_acc = m_acc, n_fdr = m_fdr;
    bit     n_upd = 0, n_tv = m_tv && !tune_ready;
    bit     n_locked = m_locked, n_ovr = m_ovr, n_stale = m_stale;
    bit     issue = 0;
    int     val = 0;
    longint fdv = longint'($signed(freqdiff));
    longint gain;
    if (!enable) begin
      n_state = S_IDLE; n_locked = 0; n_tv = 0; n_lcnt = 0; n_tcnt = 0;
    end else begin
      if (m_upd) begin
        issue = 1;
        val = int'(clamp_acc(m_acc - m_fdr * 4096) / SCALE);
      end
      case (m_state)
        S_IDLE: begin
          n_state = S_ACQ; n_acc = 32768 * SCALE; issue = 1; val = 32768;
        end
        S_ACQ, S_TRACK: begin
          if (hold) begin
            n_state = S_HOLD; n_saved = m_state;
          end else if (!stb_freqdiff && m_tcnt + 1 == TIMEOUT) begin
            n_state = S_ACQ; n_locked = 0; n_stale = 1; n_tcnt = 0; n_lcnt = 0;
          end else if (stb_freqdiff) begin
            n_tcnt = 0;
            gain = (m_state == S_TRACK) ? 256 : 16384;
            n_acc = clamp_acc(m_acc - fdv * gain);
            n_fdr = fdv;
            n_upd = 1;
            if (m_state == S_ACQ) begin
              if (mag(fdv) <= 2) begin
                n_lcnt = m_lcnt + 1;
                if (n_lcnt == 8) begin
                  n_state = S_TRACK; n_locked = 1; n_lcnt = 0;
                end
              end else begin
                n_lcnt = 0;
              end
            end else if (mag(fdv) > 16) begin
              n_state = S_ACQ; n_locked = 0;
              if (m_ucnt < 255) n_ucnt = m_ucnt + 1;
            end
          end else begin
            n_tcnt = m_tcnt + 1;
          end
        end
        default: begin
          if (!hold) begin
            n_state = m_saved; n_lcnt = 0; n_tcnt = 0;
          end
        end
      endcase
      if (issue) begin
        if (m_tv && !tune_ready) n_ovr = 1;
        n_tune = val; n_tv = 1;
      end
    end
    m_state = n_state; m_saved = n_saved; m_acc = n_acc; m_fdr = n_fdr; m_upd = n_upd;
    m_tune = n_tune; m_tv = n_tv; m_locked = n_locked; m_ovr = n_ovr; m_stale = n_stale;
    m_ucnt = n_ucnt; m_lcnt = n_lcnt; m_tcnt = n_tcnt;
  endtask

  function automatic logic [29:0] pack_dut();
    return {tune, tune_valid, locked, state_o, overrun, stale, unlock_cnt};
  endfunction

  function automatic logic [29:0] pack_model();
    return {16'(m_tune), m_tv, m_locked, 2'(m_state), m_ovr, m_stale, 8'(m_ucnt)};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    check($sformatf("outputs@cycle%0d", cyc), 64'(pack_dut()), 64'(pack_model()));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic strobe(input logic [31:0] v);
    freqdiff = v;
    stb_freqdiff = 1'b1;
    tick();
    stb_freqdiff = 1'b0;
  endtask

  function automatic logic [31:0] rnd_fd(input int a);
    int r;
    r = int'($urandom_range(0, 2 * a)) - a;
    return 32'(r);
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tune"},   64'(tune),       64'd32768);
    check({tag, "_valid"},  64'(tune_valid), 64'd0);
    check({tag, "_locked"}, 64'(locked),     64'd0);
    check({tag, "_state"},  64'(state_o),    64'd0);
    check({tag, "_ovr"},    64'(overrun),    64'd0);
    check({tag, "_stale"},  64'(stale),      64'd0);
    check({tag, "_ucnt"},   64'(unlock_cnt), 64'd0);
  endtask

  initial begin
    logic [15:0] held_tune;
    rst_n = 1'b0; enable = 1'b0; hold = 1'b0; stb_freqdiff = 1'b0;
    tune_ready = 1'b0; freqdiff = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Bring-up: IDLE then ACQ with the initial DAC write.
    tick();
    check("idle_state", 64'(state_o), 64'd0);
    enable = 1'b1;
    tick();
    check("acq_entry_state", 64'(state_o), 64'd1);
    check("acq_entry_tune", 64'(tune), 64'd32768);
    check("acq_entry_valid", 64'(tune_valid), 64'd1);
    tick();
    check("valid_held_not_ready", 64'(tune_valid), 64'd1);
    tune_ready = 1'b1;
    tick();
    check("valid_drop_on_ready", 64'(tune_valid), 64'd0);

    // Single strobe: integral at t+1, proportional-corrected tune at t+2.
    strobe(32'd100);
    tick();
    check("single_strobe_tune", 64'(tune),
          64'((32768 * SCALE - 100 * 16384 - 100 * 4096) >>> 16));
    check("single_strobe_valid", 64'(tune_valid), 64'd1);
    idle(2);

    // Seven in-lock strobes, then one just outside tolerance.
    for (int i = 0; i < 7; i++) begin
      strobe(rnd_fd(2));
      idle($urandom_range(0, 2));
    end
    strobe(32'd3);
    check("lock_restart_locked", 64'(locked), 64'd0);
    check("lock_restart_state", 64'(state_o), 64'd1);
    idle(2);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) check("lock_pending_locked", 64'(locked), 64'd0);
      strobe(rnd_fd(2));
      if (i < 7) idle($urandom_range(0, 2));
    end
    check("lock_locked", 64'(locked), 64'd1);
    check("lock_state", 64'(state_o), 64'd2);
    idle(2);

    // TRACK: stay within UNLOCK_TOL, then step just past it.
    for (int i = 0; i < 5; i++) begin
      strobe(rnd_fd(16));
      idle($urandom_range(0, 2));
    end
    strobe(-32'sd16);
    check("track_edge_state", 64'(state_o), 64'd2);
    idle(2);
    strobe(-32'sd17);
    check("unlock_state", 64'(state_o), 64'd1);
    check("unlock_locked", 64'(locked), 64'd0);
    check("unlock_count", 64'(unlock_cnt), 64'd1);
    idle(3);

    // Overrun: DAC writer stalls across two issued tunes.
    tune_ready = 1'b0;
    strobe(32'(int'($urandom_range(50, 500))));
    idle(3);
    strobe(32'(-int'($urandom_range(50, 500))));
    idle(2);
    check("overrun_flag", 64'(overrun), 64'd1);
    check("overrun_latest_tune", 64'(tune), 64'(m_tune));
    tune_ready = 1'b1;
    idle(2);

    // Saturation at both rails.
    for (int i = 0; i < 3; i++) begin
      strobe(32'h7FFF_FFFF);
      idle(2);
    end
    check("sat_low_tune", 64'(tune), 64'd0);
    for (int i = 0; i < 3; i++) begin
      strobe(32'h8000_0000);
      idle(2);
    end
    check("sat_high_tune", 64'(tune), 64'd65535);

    // Strobe timeout in ACQ.
    for (int i = 0; i < 70000 && !m_stale; i++) tick();
    idle(2);
    check("stale_flag", 64'(stale), 64'd1);
    check("stale_state", 64'(state_o), 64'd1);

    // HOLD freezes the loop and returns to the saved state.
    hold = 1'b1;
    tick();
    check("hold_state", 64'(state_o), 64'd3);
    idle(3);
    held_tune = 16'(m_tune);
    for (int i = 0; i < 3; i++) begin
      strobe(rnd_fd(5000));
      idle(2);
    end
    check("hold_tune_frozen", 64'(tune), 64'(held_tune));
    check("hold_state_kept", 64'(state_o), 64'd3);
    hold = 1'b0;
    tick();
    check("hold_return_state", 64'(state_o), 64'd1);
    idle(2);
    hold = 1'b1;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_outputs("reset_in_hold");
    hold = 1'b0;
    enable = 1'b0;
    #2;
    rst_n = 1'b1;

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      enable       = ($urandom_range(0, 39) != 0);
      hold         = ($urandom_range(0, 11) == 0);
      tune_ready   = ($urandom_range(0, 2) != 0);
      stb_freqdiff = ($urandom_range(0, 2) == 0);
      freqdiff     = ($urandom_range(0, 9) == 0) ? rnd_fd(100000) : rnd_fd(20);
      tick();
    end
    stb_freqdiff = 1'b0;
    idle(2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
